// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end.
//   state_e      : front-end FSM states
//   CMD_*        : 2-bit command codes carried in the top of each frame
//   DEF_*        : default frame/data/counter widths, shared with the master
package spi_pkg;

    localparam int unsigned DEF_FRAME_W = 10;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CNT_W   = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        WAIT_TX,
        TX,
        DONE
    } state_e;

endpackage

// File: rtl/spi_sclk_edge.sv
// Registers the clk-domain sclk level and flags its edges.
//   clk, rst_n : system clock, async active-low reset
//   sclk       : serial clock level from the master
//   rise, fall : one-clk flags, sclk rose / fell since the previous clk
module spi_sclk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    output logic rise,
    output logic fall
);

    logic sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk;
        end
    end

    assign rise = sclk & ~sclk_q;
    assign fall = ~sclk & sclk_q;

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI slave front end: deserialises {cmd, payload} frames from MOSI for the
// memory back-end and serialises read data from the back-end onto MISO.
//   clk, rst_n          : system clock, async active-low reset
//   sclk, ss_n, MOSI    : serial interface from the master (clk-domain levels)
//   MISO, valid_MISO    : reply bit and its qualifier
//   sready              : idle, ready for a new frame
//   rx_data, rx_valid   : received frame and its one-clk strobe
//   tx_data, tx_valid   : read data from the back-end
module spi_slave_frontend
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_W = DEF_FRAME_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic               valid_MISO,
    output logic               sready,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA       = CNT_W'(DATA_W);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Holds only the first FRAME_W-1 bits; the last bit goes straight to rx_data.
    logic [FRAME_W-2:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]    tx_shreg_q, tx_shreg_d;
    logic                 miso_q, miso_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_seen_q, rd_addr_seen_d;

    logic                 rise, fall;
    logic [FRAME_W-1:0]   frame_next;
    logic [1:0]           cmd;

    spi_sclk_edge u_sclk_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    assign frame_next = {shreg_q, MOSI};
    assign cmd        = frame_next[FRAME_W-1 -: 2];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        tx_shreg_d     = tx_shreg_q;
        miso_d         = miso_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;

        unique case (state_q)
            IDLE: begin
                if (!ss_n) begin
                    state_d = RX;
                    cnt_d   = '0;
                end
            end
            RX: begin
                // Abort takes priority over a coincident rise.
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    shreg_d = frame_next[FRAME_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_FRAME_LAST) begin
                        rx_data_d  = frame_next;
                        rx_valid_d = 1'b1;
                        unique case (cmd)
                            CMD_WR_ADDR, CMD_WR_DATA: state_d = DONE;
                            CMD_RD_ADDR: begin
                                state_d        = DONE;
                                rd_addr_seen_d = 1'b1;
                            end
                            CMD_RD_DATA: begin
                                // Forwarded even without a prior read address.
                                state_d        = WAIT_TX;
                                rd_addr_seen_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            WAIT_TX: begin
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tx_valid) begin
                    tx_shreg_d = tx_data;
                    cnt_d      = '0;
                    miso_d     = 1'b0;
                    state_d    = TX;
                end
            end
            TX: begin
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                end else if (fall) begin
                    if (cnt_q == CNT_DATA) begin
                        // Last bit has been held for a full sclk period.
                        state_d = DONE;
                        miso_d  = 1'b0;
                    end else begin
                        miso_d     = tx_shreg_q[DATA_W-1];
                        tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
                        cnt_d      = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (ss_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shreg_q        <= '0;
            tx_shreg_q     <= '0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            tx_shreg_q     <= tx_shreg_d;
            miso_q         <= miso_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign MISO       = miso_q;
    assign valid_MISO = (state_q == TX);
    assign sready     = (state_q == IDLE);
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
module tb_spi_slave_frontend;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ss_n;
    logic       MOSI;
    logic       MISO;
    logic       valid_MISO;
    logic       sready;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_assert = 0;
    int n_fail   = 0;
    int dut_pulses = 0;

    spi_slave_frontend dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ss_n       (ss_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .valid_MISO (valid_MISO),
        .sready     (sready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model (transaction level) ----------------
    // phase: 0 idle, 1 receiving, 2 awaiting read data, 3 replying, 4 finished
    int         m_phase;
    bit         m_prev_sclk;
    bit         m_bits[$];
    bit         m_reply[$];
    bit         m_miso;
    bit         m_pulse;
    logic [9:0] m_rx;

    function automatic void m_reset();
        m_phase     = 0;
        m_prev_sclk = 1'b0;
        m_bits.delete();
        m_reply.delete();
        m_miso      = 1'b0;
        m_pulse     = 1'b0;
        m_rx        = '0;
    endfunction

    function automatic void m_step();
        bit rise_e = sclk && !m_prev_sclk;
        bit fall_e = !sclk && m_prev_sclk;
        int f;
        m_pulse = 1'b0;
        case (m_phase)
            0: if (!ss_n) begin
                m_phase = 1;
                m_bits.delete();
            end
            1: if (ss_n) m_phase = 0;
               else if (rise_e) begin
                   m_bits.push_back(MOSI);
                   if (m_bits.size() == 10) begin
                       f = 0;
                       foreach (m_bits[i]) f = f * 2 + int'(m_bits[i]);
                       m_rx    = f[9:0];
                       m_pulse = 1'b1;
                       m_phase = (f >= 768) ? 2 : 4;  // top two bits 11 => read data
                   end
               end
            2: if (ss_n) m_phase = 0;
               else if (tx_valid) begin
                   m_reply.delete();
                   for (int i = 7; i >= 0; i--) m_reply.push_back(tx_data[i]);
                   m_miso  = 1'b0;
                   m_phase = 3;
               end
            3: if (ss_n) begin
                   m_phase = 0;
                   m_miso  = 1'b0;
               end else if (fall_e) begin
                   if (m_reply.size() > 0) m_miso = m_reply.pop_front();
                   else begin
                       m_phase = 4;
                       m_miso  = 1'b0;
                   end
               end
            default: if (ss_n) m_phase = 0;
        endcase
        m_prev_sclk = sclk;
    endfunction

    // Single compare process: advance model at posedge, compare at negedge.
    always begin
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        @(negedge clk);
        if (!rst_n) m_reset();
        if (rx_valid === 1'b1) dut_pulses++;
        check("cyc_MISO", {31'd0, MISO}, {31'd0, m_miso});
        check("cyc_valid_MISO", {31'd0, valid_MISO}, {31'd0, m_phase == 3});
        check("cyc_sready", {31'd0, sready}, {31'd0, m_phase == 0});
        check("cyc_rx_valid", {31'd0, rx_valid}, {31'd0, m_pulse});
        check("cyc_rx_data", {22'd0, rx_data}, {22'd0, m_rx});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        sclk = 1'b0;
        tick(2);
        sclk = 1'b1;
        tick(2);
    endtask

    task automatic send_frame(input logic [9:0] f);
        ss_n = 1'b0;
        tick(2);
        for (int i = 9; i >= 0; i--) send_bit(f[i]);
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic give_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
    endtask

    task automatic read_reply(input int nbits, output logic [7:0] b_o, output int vhi);
        b_o = '0;
        vhi = 0;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            tick(2);
            sclk = 1'b0;
            tick(2);
            b_o = {b_o[6:0], MISO};
            if (valid_MISO) vhi++;
        end
    endtask

    task automatic final_fall();
        check("hold_last_valid", {31'd0, valid_MISO}, 32'd1);
        sclk = 1'b1;
        tick(2);
        sclk = 1'b0;
        tick(1);
        check("valid_drop_after_8", {31'd0, valid_MISO}, 32'd0);
        tick(1);
    endtask

    // ---------------- directed test ----------------
    initial begin
        logic [7:0] b;
        int vhi;
        int p0;

        rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; MOSI = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        tick(3);
        check("rst_MISO", {31'd0, MISO}, 32'd0);
        check("rst_valid_MISO", {31'd0, valid_MISO}, 32'd0);
        check("rst_sready", {31'd0, sready}, 32'd1);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Write address
        p0 = dut_pulses;
        send_frame(10'b00_1010_0101);
        check("wr_rx_data", {22'd0, rx_data}, 32'h0A5);
        check("wr_valid_MISO", {31'd0, valid_MISO}, 32'd0);
        end_frame();
        check("wr_sready", {31'd0, sready}, 32'd1);
        check("wr_pulses", dut_pulses - p0, 32'd1);

        // Read address, then read data with reply C3
        send_frame(10'b10_0000_0011);
        check("rda_rx_data", {22'd0, rx_data}, 32'h203);
        end_frame();
        send_frame(10'b11_0000_0000);
        check("rdd_rx_data", {22'd0, rx_data}, 32'h300);
        check("rdd_wait_sready", {31'd0, sready}, 32'd0);
        give_tx(8'hC3);
        check("rdd_valid_up", {31'd0, valid_MISO}, 32'd1);
        read_reply(8, b, vhi);
        check("rdd_reply", {24'd0, b}, 32'hC3);
        check("rdd_valid_bits", vhi, 32'd8);
        final_fall();
        end_frame();

        // Abort after 6 bits, then a full frame
        p0 = dut_pulses;
        ss_n = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        ss_n = 1'b1;
        tick(1);
        check("abort_sready", {31'd0, sready}, 32'd1);
        sclk = 1'b0;
        tick(2);
        check("abort_no_pulse", dut_pulses - p0, 32'd0);
        send_frame(10'b01_1111_0000);
        check("post_abort_rx", {22'd0, rx_data}, 32'h1F0);
        end_frame();
        check("post_abort_pulses", dut_pulses - p0, 32'd1);

        // WAIT_TX stall with sclk toggling
        send_frame(10'b11_1010_1010);
        for (int i = 0; i < 10; i++) begin
            sclk = ~sclk;
            tick(2);
        end
        check("stall_MISO", {31'd0, MISO}, 32'd0);
        check("stall_valid", {31'd0, valid_MISO}, 32'd0);
        sclk = 1'b0;
        tick(2);
        give_tx(8'h5A);
        read_reply(8, b, vhi);
        check("stall_reply", {24'd0, b}, 32'h5A);
        check("stall_valid_bits", vhi, 32'd8);
        final_fall();
        end_frame();

        // Async reset mid-TX after 3 bits
        send_frame(10'b11_0000_0001);
        give_tx(8'hFF);
        read_reply(3, b, vhi);
        check("pre_rst_bits", {24'd0, b}, 32'h07);
        rst_n = 1'b0;
        ss_n  = 1'b1;
        sclk  = 1'b0;
        #1;
        check("arst_MISO", {31'd0, MISO}, 32'd0);
        check("arst_valid", {31'd0, valid_MISO}, 32'd0);
        check("arst_sready", {31'd0, sready}, 32'd1);
        check("arst_rx_data", {22'd0, rx_data}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send_frame(10'b11_0000_0010);
        give_tx(8'h96);
        read_reply(8, b, vhi);
        check("post_rst_reply", {24'd0, b}, 32'h96);
        final_fall();
        end_frame();

        // Extra sclk edges after a write frame
        p0 = dut_pulses;
        send_frame(10'b00_0101_1010);
        check("extra_rx_data", {22'd0, rx_data}, 32'h05A);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("extra_pulses", dut_pulses - p0, 32'd1);
        end_frame();

        // 10th rise coincides with ss_n high: frame discarded
        p0 = dut_pulses;
        ss_n = 1'b0;
        tick(2);
        for (int i = 0; i < 9; i++) send_bit(1'b0);
        MOSI = 1'b1;
        sclk = 1'b0;
        tick(2);
        sclk = 1'b1;
        ss_n = 1'b1;
        tick(3);
        check("coinc_no_pulse", dut_pulses - p0, 32'd0);
        check("coinc_sready", {31'd0, sready}, 32'd1);
        check("coinc_rx_data", {22'd0, rx_data}, 32'h05A);
        sclk = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- SPI slave stage directly downstream of the SPI master; consumes sclk, ss_n and MOSI, and returns MISO, valid_MISO and sready to the master.
- Deserialises 10-bit command frames (2-bit command + 8-bit payload) and hands them to the memory back-end.
- Accepts read data from the memory back-end and serialises it back to the master.
- Fully synchronous to clk; sclk is a clk-domain level, and its edges are detected by registering it.

Parameters:
- FRAME_W, 10, bits per received frame (command + payload).
- DATA_W, 8, bits per read-data reply on MISO.
- CNT_W, 4, bit counter width; must satisfy 2**CNT_W > FRAME_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  serial clock from master, clk-domain level.
- ss_n  in  1  slave select from master, active low.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial read data to master.
- valid_MISO  out  1  high while MISO carries reply bits.
- sready  out  1  slave idle and able to accept a new frame.
- rx_data  out  FRAME_W  received frame {cmd[1:0], payload[7:0]}.
- rx_valid  out  1  one-clk pulse, rx_data valid.
- tx_data  in  DATA_W  read data from back-end.
- tx_valid  in  1  tx_data valid (level, sampled in WAIT_TX).

Behaviour:
- Reset values: MISO=0, valid_MISO=0, sready=1, rx_data=0, rx_valid=0, state=IDLE, counter=0, rd_addr_seen=0, sclk_q=0.
- Edge detection:
  - rise = sclk & ~sclk_q.
  - fall = ~sclk & sclk_q.
  - sclk_q is registered every clk.
- MOSI is sampled on rise. MISO is updated on fall.
- State IDLE:
  - sready=1.
  - ss_n low -> RX; clear counter.
- State RX:
  - sready=0.
  - On each rise, shift MOSI into shreg MSB-first and increment counter.
  - When counter reaches FRAME_W (bit 10 captured): rx_data <= shreg, rx_valid pulses for exactly one clk in the following cycle.
  - Next state is decided by cmd = first two bits:
    - 00 or 01 (write addr/data) -> DONE.
    - 10 (read addr) -> DONE; set rd_addr_seen=1.
    - 11 (read data) -> WAIT_TX; clear rd_addr_seen.
  - cmd 11 while rd_addr_seen=0 is still forwarded; the back-end owns address validity.
- State WAIT_TX:
  - Wait for tx_valid=1; latch tx_data into tx_shreg, clear counter -> TX.
  - sclk edges are ignored while waiting.
- State TX:
  - valid_MISO=1.
  - On each fall, MISO <= tx_shreg MSB, shift left, increment counter.
  - After DATA_W bits have been driven, hold the last bit until the next fall, then drop valid_MISO -> DONE.
- State DONE:
  - Wait for ss_n high -> IDLE.
  - Extra sclk edges are ignored, and no second rx_valid is produced.
- Abort: ss_n high in RX, WAIT_TX or TX -> IDLE on the next clk.
  - No rx_valid for a partial frame.
  - valid_MISO drops the same clk the state leaves TX.
  - Counters clear.
- Simultaneous rise and ss_n rising in the same clk: abort wins and the bit is discarded.
- If the 10th rise and ss_n high coincide, the frame is discarded.
- Counter never wraps: it saturates at FRAME_W in RX and at DATA_W in TX.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately; rd_addr_seen is cleared.
- Latency: rx_valid rises 1 clk after the clk in which the 10th rise is detected. The first MISO bit appears on the first fall after the clk in which tx_valid is accepted.

Decomposition:
- Package spi_pkg:
  - typedef enum state_e {IDLE, RX, WAIT_TX, TX, DONE}.
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W and DATA_W defaults, shared with the master.
- One natural sub-module: spi_sclk_edge (registers sclk, outputs rise/fall). Everything else stays in one module.

Test Plan:
- Write address: ss_n low, MOSI bits 00_1010_0101 on 10 rises -> one rx_valid pulse with rx_data=10'h0A5; valid_MISO stays 0; after ss_n high, sready=1.
- Read address then read data:
  - Frame 10_0000_0011 -> rx_data=10'h203.
  - Frame 11_xxxx_xxxx, then back-end drives tx_valid with tx_data=8'hC3 -> MISO bits 1,1,0,0,0,0,1,1 on successive falls, valid_MISO high for exactly 8 fall intervals.
- Abort: ss_n high after 6 rises -> no rx_valid, state IDLE, sready=1 next clk; a following full frame 01_1111_0000 gives rx_data=10'h1F0.
- WAIT_TX stall: tx_valid held low for 20 clks with sclk toggling -> MISO=0, valid_MISO=0, no shifting; tx_valid=1 with 8'h5A -> reply 0,1,0,1,1,0,1,0.
- Async reset: rst_n low mid-TX after 3 bits -> MISO=0, valid_MISO=0, sready=1 in the same cycle; the next read-data frame replies correctly from bit 0.
- Extra sclk edges after the 10th bit of a write, with ss_n still low -> exactly one rx_valid pulse.
